// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL loop filter and its phase-detector neighbours.
package adpll_pkg;

  localparam int unsigned INT_W_DEF  = 16;
  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned FRAC_W     = INT_W_DEF - CTRL_W_DEF;
  localparam int unsigned CTRL_INIT  = 128;

  localparam logic [1:0] KP_DEF = 2'd2;
  localparam logic [2:0] KI_DEF = 3'd4;

  // pgm_value field positions: [4:3] kp_shift, [2:0] ki_shift
  localparam int unsigned PGM_KP_HI = 4;
  localparam int unsigned PGM_KP_LO = 3;
  localparam int unsigned PGM_KI_HI = 2;
  localparam int unsigned PGM_KI_LO = 0;

  // Two's-complement phase error as produced by the bang-bang detector
  typedef enum logic [1:0] {
    ERR_ZERO = 2'b00,
    ERR_POS  = 2'b01,
    ERR_NEG  = 2'b11
  } pd_err_e;

  function automatic pd_err_e pd_error(input logic up, input logic dn);
    if (up && !dn)      return ERR_POS;
    else if (dn && !up) return ERR_NEG;
    else                return ERR_ZERO;
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Bang-bang dither lock detector: counts sign reversals of the phase error per window.
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int unsigned LOCK_WIN = 64
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    sample,
  input  pd_err_e err,
  input  logic    clear,
  output logic    lock_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_WIN + 1);

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] trans_cnt;
  logic [CNT_W-1:0] trans_nx;
  logic             have_sign;
  logic             last_neg;

  // Transition count including the current sample
  always_comb begin
    trans_nx = trans_cnt;
    if (err != ERR_ZERO && have_sign && ((err == ERR_NEG) != last_neg))
      trans_nx = trans_cnt + CNT_W'(1);
  end

  // Window/transition counters, sign tracker and lock decision at window end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      trans_cnt <= '0;
      have_sign <= 1'b0;
      last_neg  <= 1'b0;
      lock_o    <= 1'b0;
    end else if (clear) begin
      win_cnt   <= '0;
      trans_cnt <= '0;
      lock_o    <= 1'b0;
    end else if (sample) begin
      if (win_cnt == CNT_W'(LOCK_WIN - 1)) begin
        lock_o    <= (trans_nx >= CNT_W'(LOCK_WIN / 4));
        win_cnt   <= '0;
        trans_cnt <= '0;
      end else begin
        win_cnt   <= win_cnt + CNT_W'(1);
        trans_cnt <= trans_nx;
      end
      if (err != ERR_ZERO) begin
        have_sign <= 1'b1;
        last_neg  <= (err == ERR_NEG);
      end
    end
  end

endmodule

// File: rtl/adpll_loop_filter.sv
// Proportional-integral loop filter: bang-bang UP/DN -> saturated DCO control word.
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int unsigned INT_W     = INT_W_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned CTRL_INIT = adpll_pkg::CTRL_INIT,
  parameter int unsigned LOCK_WIN  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pd_valid_i,
  input  logic              up_i,
  input  logic              dn_i,
  input  logic              pgm_i,
  input  logic [4:0]        pgm_value_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              ctrl_valid_o,
  output logic              lock_o,
  output logic              sat_o
);

  localparam int unsigned FRAC = INT_W - CTRL_W;
  // Two guard bits keep integ+inc and integ'+prop exact before clamping
  localparam int unsigned W    = INT_W + 2;

  localparam logic signed [W-1:0] INT_MAX  = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [W-1:0] INT_MIN  = {3'b111, {(INT_W-1){1'b0}}};
  localparam logic signed [W-1:0] CTRL_MAX = W'((1 << CTRL_W) - 1);
  localparam logic signed [W-1:0] CTRL_OFS = W'(CTRL_INIT);

  logic                    pgm_q;
  logic [1:0]              kp_shift;
  logic [2:0]              ki_shift;
  logic signed [INT_W-1:0] integ;

  pd_err_e                 err;
  logic                    update;
  logic                    gain_load;
  logic signed [W-1:0]     e_w;
  logic signed [W-1:0]     inc;
  logic signed [W-1:0]     prop;
  logic signed [W-1:0]     sum_i;
  logic signed [W-1:0]     integ_c;
  logic signed [W-1:0]     tot;
  logic signed [W-1:0]     ctrl_raw;
  logic [CTRL_W-1:0]       ctrl_nx;
  logic                    sat_nx;

  assign err       = pd_error(up_i, dn_i);
  assign update    = ena && !pgm_i && pd_valid_i;
  assign gain_load = ena && pgm_i && !pgm_q;

  // Integrator clamp, proportional path and clipped control word for this update
  always_comb begin
    e_w      = {{(W-2){err[1]}}, err};
    inc      = e_w <<< (FRAC - 32'(ki_shift));
    prop     = e_w <<< (FRAC - 32'(kp_shift));
    sum_i    = {{2{integ[INT_W-1]}}, integ} + inc;
    integ_c  = sum_i;
    sat_nx   = 1'b0;
    if (sum_i > INT_MAX) begin
      integ_c = INT_MAX;
      sat_nx  = 1'b1;
    end else if (sum_i < INT_MIN) begin
      integ_c = INT_MIN;
      sat_nx  = 1'b1;
    end
    tot      = integ_c + prop;
    ctrl_raw = (tot >>> FRAC) + CTRL_OFS;
    ctrl_nx  = ctrl_raw[CTRL_W-1:0];
    if (ctrl_raw < 0) begin
      ctrl_nx = '0;
      sat_nx  = 1'b1;
    end else if (ctrl_raw > CTRL_MAX) begin
      ctrl_nx = '1;
      sat_nx  = 1'b1;
    end
  end

  // Gain registers, pgm edge detector, integrator and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pgm_q        <= 1'b0;
      kp_shift     <= KP_DEF;
      ki_shift     <= KI_DEF;
      integ        <= '0;
      ctrl_o       <= CTRL_W'(CTRL_INIT);
      ctrl_valid_o <= 1'b0;
      sat_o        <= 1'b0;
    end else if (ena) begin
      pgm_q        <= pgm_i;
      ctrl_valid_o <= 1'b0;
      if (gain_load) begin
        kp_shift <= pgm_value_i[PGM_KP_HI:PGM_KP_LO];
        ki_shift <= pgm_value_i[PGM_KI_HI:PGM_KI_LO];
      end
      if (update) begin
        integ        <= integ_c[INT_W-1:0];
        ctrl_o       <= ctrl_nx;
        ctrl_valid_o <= 1'b1;
        sat_o        <= sat_nx;
      end
    end
  end

  adpll_lock_detect #(
    .LOCK_WIN (LOCK_WIN)
  ) u_lock (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (update),
    .err    (err),
    .clear  (gain_load),
    .lock_o (lock_o)
  );

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Directed self-checking bench for adpll_loop_filter.
module tb_adpll_loop_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       pd_valid_i;
  logic       up_i;
  logic       dn_i;
  logic       pgm_i;
  logic [4:0] pgm_value_i;
  logic [7:0] ctrl_o;
  logic       ctrl_valid_o;
  logic       lock_o;
  logic       sat_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ena;
    logic       pgm;
    logic [4:0] pv;
    logic       vld;
    logic       up;
    logic       dn;
    logic [7:0] ctrl;
    logic       valid;
    logic       lock;
    logic       sat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  adpll_loop_filter #(
    .INT_W     (16),
    .CTRL_W    (8),
    .CTRL_INIT (128),
    .LOCK_WIN  (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .pd_valid_i   (pd_valid_i),
    .up_i         (up_i),
    .dn_i         (dn_i),
    .pgm_i        (pgm_i),
    .pgm_value_i  (pgm_value_i),
    .ctrl_o       (ctrl_o),
    .ctrl_valid_o (ctrl_valid_o),
    .lock_o       (lock_o),
    .sat_o        (sat_o)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] c, input logic v,
                         input logic l, input logic s);
    chk({name, ".ctrl"},  ctrl_o,               c);
    chk({name, ".valid"}, {7'd0, ctrl_valid_o}, {7'd0, v});
    chk({name, ".lock"},  {7'd0, lock_o},       {7'd0, l});
    chk({name, ".sat"},   {7'd0, sat_o},        {7'd0, s});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic step(input logic en, input logic pg, input logic [4:0] pv,
                      input logic vl, input logic u, input logic d);
    ena = en; pgm_i = pg; pgm_value_i = pv; pd_valid_i = vl; up_i = u; dn_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic pg, input logic [4:0] pv, input logic vl,
                      input logic u, input logic d, input logic [7:0] c,
                      input logic v, input logic l, input logic s);
    vec_t x;
    x.ena = 1'b1; x.pgm = pg; x.pv = pv; x.vld = vl; x.up = u; x.dn = d;
    x.ctrl = c; x.valid = v; x.lock = l; x.sat = s;
    vecs.push_back(x);
  endtask

  initial begin
    // Default gains kp=2 ki=4: inc 16, prop 64; 12th up gives 192+64=256 -> 129
    for (int k = 1; k <= 12; k++) begin
      push(0, 5'd0, 1, 1, 0, (k < 12) ? 8'd128 : 8'd129, 1, 0, 0);
      push(0, 5'd0, 0, 0, 0, (k < 12) ? 8'd128 : 8'd129, 0, 0, 0);
    end
    // Gain load 0/0 with strobes ignored while pgm_i is high
    push(1, 5'b00000, 1, 1, 0, 8'd129, 0, 0, 0);
    push(1, 5'b00000, 1, 0, 1, 8'd129, 0, 0, 0);
    push(0, 5'b00000, 0, 0, 0, 8'd129, 0, 0, 0);
    // integ 192+256=448, +256 -> 704>>8=2 -> 130; dn: 192-256=-64 -> -1 -> 127
    push(0, 5'd0, 1, 1, 0, 8'd130, 1, 0, 0);
    push(0, 5'd0, 1, 0, 1, 8'd127, 1, 0, 0);
    push(0, 5'd0, 0, 0, 0, 8'd127, 0, 0, 0);

    rst_n = 1'b0;
    ena = 1'b1; pd_valid_i = 1'b0; up_i = 1'b0; dn_i = 1'b0;
    pgm_i = 1'b0; pgm_value_i = 5'd0;
    #12;
    chk_all("reset", 8'd128, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 5'd0, 0, 0, 0);
    chk_all("post_reset_idle", 8'd128, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ena, vecs[i].pgm, vecs[i].pv, vecs[i].vld, vecs[i].up, vecs[i].dn);
      chk_all($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].valid, vecs[i].lock, vecs[i].sat);
    end

    // Gains 0/0 from integ=192: up #126 -> 32448+256 -> 255 exact; #127 clips; later integ clamps
    for (int k = 1; k <= 140; k++) begin
      step(1, 0, 5'd0, 1, 1, 0);
      if (k == 126) chk_all("sat_edge126", 8'd255, 1, 0, 0);
      if (k == 127) chk_all("sat_clip127", 8'd255, 1, 0, 1);
      if (k == 140) chk_all("sat_clamp140", 8'd255, 1, 0, 1);
    end
    // integ 32767 (no wrap) - 256 = 32511, -256 prop -> 32255>>8 = 125 -> 253
    step(1, 0, 5'd0, 1, 0, 1);
    chk_all("sat_release_dn", 8'd253, 1, 0, 0);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 8'd128, 0, 0, 0);
    #2 rst_n = 1'b1;
    step(1, 0, 5'd0, 0, 0, 0);
    chk_all("async_reset_release", 8'd128, 0, 0, 0);

    // 64 alternating samples: 63 transitions -> lock at window end
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 5'd0, 1, (i % 2) == 0, (i % 2) != 0);
      chk_all($sformatf("lock_alt%0d", i), ((i % 2) == 0) ? 8'd128 : 8'd127, 1, i == 63, 0);
    end
    // 64 up-only samples: 1 transition -> unlock at window end
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 5'd0, 1, 1, 0);
      if (i == 62) chk_all("lock_hold", 8'd132, 1, 1, 0);
      if (i == 63) chk_all("lock_drop", 8'd132, 1, 0, 0);
    end
    // up&dn together: e=0, prop 0, integ 1024 -> 132, valid still pulses
    step(1, 0, 5'd0, 1, 1, 1);
    chk_all("both_updn", 8'd132, 1, 0, 0);
    step(1, 0, 5'd0, 0, 0, 0);
    chk_all("idle_after_both", 8'd132, 0, 0, 0);

    // ena=0 freezes everything, including the pgm edge detector
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 5'd0, 1, 1, 0);
      chk_all($sformatf("ena_off%0d", i), 8'd132, 0, 0, 0);
    end
    step(0, 1, 5'd0, 1, 0, 1);
    chk_all("ena_off_pgm", 8'd132, 0, 0, 0);
    step(1, 1, 5'd0, 1, 1, 0);
    chk_all("ena_on_pgm", 8'd132, 0, 0, 0);
    // Gains 0/0 loaded only if the edge was seen after ena returned: 1280+256 -> 6 -> 134
    step(1, 0, 5'd0, 1, 1, 0);
    chk_all("gain_after_ena", 8'd134, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
